// File: rtl/cache_main_mem_responder_if.sv
// cache_main_mem_responder_if: cache-to-main-memory port with a shared bidirectional data bus.
interface cache_main_mem_responder_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] addr_mem;
    logic              rd_mem;
    logic              wr_mem;
    logic              ready_mem;
    logic              beat_valid;
    logic              protocol_err;
    logic              rsp_oe;
    logic [DATA_W-1:0] rsp_data;
    logic              host_oe;
    logic [DATA_W-1:0] host_data;
    wire  [DATA_W-1:0] data_mem;
    // Both ends drive through enables so the resolved bus floats when nobody owns it.
    assign data_mem = rsp_oe ? rsp_data : (host_oe ? host_data : {DATA_W{1'bz}});
    modport slave (
        input  addr_mem, rd_mem, wr_mem, data_mem,
        output ready_mem, beat_valid, protocol_err, rsp_oe, rsp_data
    );
    modport master (
        output addr_mem, rd_mem, wr_mem, host_oe, host_data,
        input  data_mem, ready_mem, beat_valid, protocol_err
    );
endinterface

// File: rtl/cache_main_mem_responder.sv
// cache_main_mem_responder: byte-array main memory serving cache line fills and write-backs with programmable busy latency
module cache_main_mem_responder #(
    parameter int    ADDR_W     = 16,
    parameter int    DATA_W     = 8,
    parameter int    LINE_BYTES = 4,
    parameter int    MEM_AW     = 12,
    parameter int    LATENCY    = 4,
    parameter string INIT_FILE  = ""
) (
    input logic clk_i,
    input logic rst_i,
    cache_main_mem_responder_if.slave bus
);
    localparam int OFF_W   = $clog2(LINE_BYTES);
    localparam int LINE_AW = MEM_AW - OFF_W;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BUSY  = 2'd1;
    localparam logic [1:0] BURST = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;
    localparam logic [3:0] LAT_LOAD = LATENCY > 0 ? 4'(LATENCY - 1) : 4'd0;
    localparam logic [OFF_W-1:0] LAST = OFF_W'(LINE_BYTES - 1);

    logic [DATA_W-1:0]  mem_q [2**MEM_AW];
    logic [1:0]         state_q, state_d;
    logic [LINE_AW-1:0] base_q, base_d;
    logic [OFF_W-1:0]   beat_q, beat_d;
    logic [3:0]         lat_q, lat_d;
    logic               op_q, op_d;
    logic               err_q, err_d;
    logic [DATA_W-1:0]  rd_data_q;
    logic               act_s, opp_s, wr_en_s;
    logic               unused_addr;

    assign unused_addr = ^{bus.addr_mem[ADDR_W-1:MEM_AW], bus.addr_mem[OFF_W-1:0]};
    assign act_s   = op_q ? bus.rd_mem : bus.wr_mem;
    assign opp_s   = op_q ? bus.wr_mem : bus.rd_mem;
    assign wr_en_s = state_q == BURST && !op_q && bus.wr_mem;

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        op_d    = op_q;
        beat_d  = beat_q;
        lat_d   = lat_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (bus.rd_mem || bus.wr_mem) begin
                state_d = LATENCY > 0 ? BUSY : BURST;
                base_d  = bus.addr_mem[MEM_AW-1:OFF_W];
                op_d    = bus.rd_mem;
                beat_d  = '0;
                lat_d   = LAT_LOAD;
                err_d   = err_q || (bus.rd_mem && bus.wr_mem);
            end
            BUSY: begin
                state_d = !act_s ? IDLE : (lat_q == 4'd0 ? BURST : BUSY);
                lat_d   = lat_q == 4'd0 ? lat_q : lat_q - 4'd1;
                err_d   = err_q || opp_s || !act_s;
            end
            BURST: begin
                state_d = !act_s ? IDLE : (beat_q == LAST ? DRAIN : BURST);
                beat_d  = beat_q + 1'b1;
                err_d   = err_q || opp_s || !act_s;
            end
            default: state_d = (bus.rd_mem || bus.wr_mem) ? DRAIN : IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            beat_q  <= '0;
            lat_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            lat_q   <= lat_d;
            err_q   <= err_d;
        end
        base_q <= base_d;
        op_q   <= op_d;
    end

    always_ff @(posedge clk_i) begin
        rd_data_q <= mem_q[{base_d, beat_d}];
        if (!rst_i && wr_en_s)
            mem_q[{base_q, beat_q}] <= bus.data_mem;
    end

    assign bus.ready_mem    = state_q != BUSY;
    assign bus.beat_valid   = state_q == BURST;
    assign bus.protocol_err = err_q;
    assign bus.rsp_oe       = state_q == BURST && op_q && !bus.wr_mem;
    assign bus.rsp_data     = rd_data_q;
endmodule

// File: tb/tb_cache_main_mem_responder.sv
// tb_cache_main_mem_responder: directed checks of a LATENCY=4 and a LATENCY=0 responder.
module tb_cache_main_mem_responder;
    localparam logic [7:0] PAT [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sel = 1'b0;
    logic [15:0] addr = '0;
    logic rd = 1'b0, wr = 1'b0, hoe = 1'b0;
    logic [7:0] hdata = '0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cache_main_mem_responder_if #(.ADDR_W(16), .DATA_W(8)) bus0 ();
    cache_main_mem_responder_if #(.ADDR_W(16), .DATA_W(8)) bus1 ();

    assign bus0.addr_mem  = addr;
    assign bus0.rd_mem    = rd && !sel;
    assign bus0.wr_mem    = wr && !sel;
    assign bus0.host_oe   = hoe && !sel;
    assign bus0.host_data = hdata;
    assign bus1.addr_mem  = addr;
    assign bus1.rd_mem    = rd && sel;
    assign bus1.wr_mem    = wr && sel;
    assign bus1.host_oe   = hoe && sel;
    assign bus1.host_data = hdata;

    cache_main_mem_responder #(.LATENCY(4)) u0 (.clk_i(clk), .rst_i(rst), .bus(bus0));
    cache_main_mem_responder #(.LATENCY(0)) u1 (.clk_i(clk), .rst_i(rst), .bus(bus1));

    logic ready, bv, perr, oe;
    logic [7:0] dm;
    assign ready = sel ? bus1.ready_mem    : bus0.ready_mem;
    assign bv    = sel ? bus1.beat_valid   : bus0.beat_valid;
    assign perr  = sel ? bus1.protocol_err : bus0.protocol_err;
    assign oe    = sel ? bus1.rsp_oe       : bus0.rsp_oe;
    assign dm    = sel ? bus1.data_mem     : bus0.data_mem;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; rd = 1'b0; wr = 1'b0; hoe = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic burst_write(input logic [15:0] a, input logic [31:0] w, output int low);
        int n = 0;
        low = 0;
        addr = a; wr = 1'b1; hoe = 1'b1; hdata = w[31:24];
        tick();
        while (!bv && n < 20) begin
            low += ready ? 0 : 1;
            n++;
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            hdata = w[31-8*i -: 8];
            tick();
        end
        wr = 1'b0; hoe = 1'b0;
        tick();
    endtask

    task automatic burst_read(input logic [15:0] a, output logic [31:0] got, output int low,
                              output int nb);
        int n = 0;
        low = 0; nb = 0; got = '0;
        addr = a; rd = 1'b1;
        tick();
        while (!bv && n < 20) begin
            low += ready ? 0 : 1;
            n++;
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            got[31-8*i -: 8] = dm;
            nb += (bv && oe) ? 1 : 0;
            tick();
        end
        rd = 1'b0;
        tick();
    endtask

    task automatic test_reset;
        sel = 1'b0;
        do_reset();
        checks++;
        if ({ready, bv, perr, oe} !== 4'b1000) begin
            errors++;
            $display("FAIL reset: ready/bv/err/oe=%b expected 1000", {ready, bv, perr, oe});
        end
    endtask

    task automatic test_write_back;
        int low = 0;
        addr = 16'h0093; wr = 1'b1; hoe = 1'b1; hdata = PAT[0];
        tick();
        for (int i = 0; i < 4; i++) begin
            low += (!ready && !bv) ? 1 : 0;
            tick();
        end
        checks++;
        if (low !== 4) begin
            errors++;
            $display("FAIL wb_busy: low cycles=%0d expected 4", low);
        end
        for (int i = 0; i < 4; i++) begin
            hdata = PAT[i];
            checks++;
            if ({ready, bv} !== 2'b11) begin
                errors++;
                $display("FAIL wb_beat%0d: ready/bv=%b expected 11", i, {ready, bv});
            end
            tick();
        end
        wr = 1'b0; hoe = 1'b0;
        tick();
        checks++;
        if ({ready, bv, perr} !== 3'b100) begin
            errors++;
            $display("FAIL wb_end: ready/bv/err=%b expected 100", {ready, bv, perr});
        end
    endtask

    task automatic test_line_fill;
        int low = 0;
        addr = 16'h0091; rd = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            low += (!ready && !bv) ? 1 : 0;
            tick();
        end
        checks++;
        if (low !== 4) begin
            errors++;
            $display("FAIL fill_busy: low cycles=%0d expected 4", low);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({bv, oe, ready} !== 3'b111 || dm !== PAT[i]) begin
                errors++;
                $display("FAIL fill_beat%0d: bv/oe/ready=%b data=%h expected 111 %h",
                         i, {bv, oe, ready}, dm, PAT[i]);
            end
            tick();
        end
        checks++;
        if ({bv, oe, ready} !== 3'b001) begin
            errors++;
            $display("FAIL fill_release: bv/oe/ready=%b expected 001", {bv, oe, ready});
        end
        rd = 1'b0;
        tick();
    endtask

    task automatic test_alias;
        int low, nb;
        logic [31:0] got;
        burst_write(16'h0FFC, 32'h11223344, low);
        burst_read(16'hFFFF, got, low, nb);
        checks++;
        if (got !== 32'h11223344 || nb !== 4 || low !== 4) begin
            errors++;
            $display("FAIL alias_ffff: data=%h beats=%0d low=%0d expected 11223344 4 4", got, nb, low);
        end
        burst_read(16'h1FFD, got, low, nb);
        checks++;
        if (got !== 32'h11223344) begin
            errors++;
            $display("FAIL alias_1ffd: data=%h expected 11223344", got);
        end
    endtask

    task automatic test_reset_mid_burst;
        int n = 0, low, nb;
        logic [31:0] got;
        addr = 16'h0090; rd = 1'b1;
        tick();
        while (!bv && n < 20) begin
            n++;
            tick();
        end
        tick();
        tick();
        checks++;
        if (dm !== PAT[2] || bv !== 1'b1) begin
            errors++;
            $display("FAIL mid_beat2: data=%h bv=%b expected %h 1", dm, bv, PAT[2]);
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({ready, bv, oe} !== 3'b100) begin
            errors++;
            $display("FAIL mid_abort: ready/bv/oe=%b expected 100", {ready, bv, oe});
        end
        rst = 1'b0; rd = 1'b0;
        tick();
        burst_read(16'h0090, got, low, nb);
        checks++;
        if (got !== 32'hA1B2C3D4 || nb !== 4) begin
            errors++;
            $display("FAIL mid_reread: data=%h beats=%0d expected a1b2c3d4 4", got, nb);
        end
    endtask

    task automatic test_both_strobes;
        int n = 0, nb = 0, no = 0, low;
        logic [31:0] got;
        addr = 16'h0090; rd = 1'b1; wr = 1'b1; hoe = 1'b0;
        tick();
        checks++;
        if (perr !== 1'b1) begin
            errors++;
            $display("FAIL both_err: err=%b expected 1", perr);
        end
        while (!bv && n < 20) begin
            n++;
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            nb += bv ? 1 : 0;
            no += oe ? 1 : 0;
            tick();
        end
        checks++;
        if (nb !== 4 || no !== 0 || bv !== 1'b0) begin
            errors++;
            $display("FAIL both_burst: beats=%0d driven=%0d bv_after=%b expected 4 0 0", nb, no, bv);
        end
        rd = 1'b0; wr = 1'b0;
        tick();
        burst_read(16'h0090, got, low, nb);
        checks++;
        if (got !== 32'hA1B2C3D4 || perr !== 1'b1) begin
            errors++;
            $display("FAIL both_after: data=%h err=%b expected a1b2c3d4 1", got, perr);
        end
    endtask

    task automatic test_strobe_drop;
        do_reset();
        addr = 16'h0090; rd = 1'b1;
        tick();
        tick();
        rd = 1'b0;
        tick();
        checks++;
        if ({ready, bv, perr} !== 3'b101) begin
            errors++;
            $display("FAIL drop_abort: ready/bv/err=%b expected 101", {ready, bv, perr});
        end
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if ({ready, bv, perr} !== 3'b101) begin
            errors++;
            $display("FAIL drop_sticky: ready/bv/err=%b expected 101", {ready, bv, perr});
        end
        do_reset();
        checks++;
        if (perr !== 1'b0) begin
            errors++;
            $display("FAIL drop_clear: err=%b expected 0", perr);
        end
    endtask

    task automatic test_latency0;
        int low, bad = 0;
        logic [31:0] w = 32'h5A6B7C8D;
        sel = 1'b1;
        do_reset();
        burst_write(16'h0040, w, low);
        checks++;
        if (low !== 0) begin
            errors++;
            $display("FAIL lat0_wr_busy: low cycles=%0d expected 0", low);
        end
        addr = 16'h0041; rd = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({bv, oe, ready} !== 3'b111 || dm !== w[31-8*i -: 8]) begin
                errors++;
                $display("FAIL lat0_beat%0d: bv/oe/ready=%b data=%h expected 111 %h",
                         i, {bv, oe, ready}, dm, w[31-8*i -: 8]);
            end
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            bad += (bv || !ready) ? 1 : 0;
            tick();
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL lat0_hold: retrigger cycles=%0d expected 0", bad);
        end
        rd = 1'b0;
        tick();
        rd = 1'b1;
        tick();
        checks++;
        if (bv !== 1'b1 || dm !== 8'h5A) begin
            errors++;
            $display("FAIL lat0_rearm: bv=%b data=%h expected 1 5a", bv, dm);
        end
        for (int i = 0; i < 4; i++) tick();
        rd = 1'b0;
        tick();
        sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write_back();
        test_line_fill();
        test_alias();
        test_reset_mid_burst();
        test_both_strobes();
        test_strobe_drop();
        test_latency0();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
